// File: rtl/clock_stepper.sv
// Run/halt/step clock-enable sequencer: holds the core in reset for a boot window,
// then emits a registered ce in run, slow, single-step or burst mode.
module clock_stepper #(
   parameter int unsigned BOOT_CYCLES = 4096,
   parameter int unsigned DIV_BITS    = 24,
   parameter int unsigned DEB_BITS    = 16,
   parameter int unsigned BURST_BITS  = 8
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic [1:0]            mode,
   input  logic [4:0]            slow_sel,
   input  logic                  step_btn,
   input  logic                  burst_go,
   input  logic [BURST_BITS-1:0] burst_len,
   output logic                  ce,
   output logic                  resetn,
   output logic                  busy,
   output logic [31:0]           cycle_count
);

   typedef enum logic [2:0] {
      S_BOOT,
      S_HALT,
      S_RUN,
      S_SLOW,
      S_BURST
   } state_t;

   localparam logic [15:0] BOOT_LAST = 16'(BOOT_CYCLES - 1);

   state_t                state, state_nxt;
   logic [15:0]           boot_cnt, boot_cnt_nxt;
   logic [DIV_BITS-1:0]   div_cnt, div_cnt_nxt, div_mask;
   logic [BURST_BITS-1:0] burst_cnt, burst_cnt_nxt;
   logic                  ce_nxt;

   logic                  sync_a, sync_b, deb_level, step_pulse;
   logic [DEB_BITS-1:0]   deb_cnt;

   // step_pulse is a one-cycle flag on a debounced press; it is consumed only in HALT
   always_ff @(posedge CLK) begin
      if (RESET) begin
         sync_a     <= 1'b0;
         sync_b     <= 1'b0;
         deb_level  <= 1'b0;
         deb_cnt    <= '0;
         step_pulse <= 1'b0;
      end else begin
         sync_a     <= step_btn;
         sync_b     <= sync_a;
         step_pulse <= 1'b0;
         if (sync_b == deb_level) begin
            deb_cnt <= '0;
         end else if (&deb_cnt) begin
            deb_level  <= ~deb_level;
            deb_cnt    <= '0;
            step_pulse <= ~deb_level;
         end else begin
            deb_cnt <= deb_cnt + DEB_BITS'(1);
         end
      end
   end

   // exponents beyond DIV_BITS saturate to an all-ones mask
   always_comb begin
      div_mask = '0;
      for (int unsigned i = 0; i < DIV_BITS; i++) begin
         if (i < 32'(slow_sel)) div_mask[i] = 1'b1;
      end
   end

   always_comb begin
      state_nxt     = state;
      ce_nxt        = 1'b0;
      boot_cnt_nxt  = boot_cnt;
      div_cnt_nxt   = div_cnt;
      burst_cnt_nxt = burst_cnt;
      case (state)
         S_BOOT: begin
            if (boot_cnt == BOOT_LAST) begin
               div_cnt_nxt = '0;
               case (mode)
                  2'b01:   state_nxt = S_RUN;
                  2'b10:   state_nxt = S_SLOW;
                  default: state_nxt = S_HALT;
               endcase
            end else begin
               boot_cnt_nxt = boot_cnt + 16'd1;
            end
         end
         S_BURST: begin
            if (burst_cnt == BURST_BITS'(1)) begin
               state_nxt = S_HALT;
            end else begin
               burst_cnt_nxt = burst_cnt - BURST_BITS'(1);
               ce_nxt        = 1'b1;
            end
         end
         default: begin
            case (mode)
               2'b01: begin
                  state_nxt = S_RUN;
                  ce_nxt    = 1'b1;
               end
               2'b10: begin
                  state_nxt = S_SLOW;
                  if (state != S_SLOW) begin
                     div_cnt_nxt = '0;
                  end else begin
                     div_cnt_nxt = div_cnt + DIV_BITS'(1);
                     ce_nxt      = ((div_cnt & div_mask) == div_mask);
                  end
               end
               default: begin
                  state_nxt = S_HALT;
                  // burst load emits the first ce itself, so busy and ce align
                  if (state == S_HALT && burst_go && burst_len != '0) begin
                     state_nxt     = S_BURST;
                     burst_cnt_nxt = burst_len;
                     ce_nxt        = 1'b1;
                  end else if (state == S_HALT && step_pulse) begin
                     ce_nxt = 1'b1;
                  end
               end
            endcase
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state       <= S_BOOT;
         boot_cnt    <= '0;
         div_cnt     <= '0;
         burst_cnt   <= '0;
         ce          <= 1'b0;
         resetn      <= 1'b0;
         busy        <= 1'b1;
         cycle_count <= '0;
      end else begin
         state       <= state_nxt;
         boot_cnt    <= boot_cnt_nxt;
         div_cnt     <= div_cnt_nxt;
         burst_cnt   <= burst_cnt_nxt;
         ce          <= ce_nxt;
         resetn      <= (state_nxt != S_BOOT);
         busy        <= (state_nxt == S_BOOT) || (state_nxt == S_BURST);
         cycle_count <= cycle_count + 32'(ce);
      end
   end

endmodule

// File: tb/tb_clock_stepper.sv
// Bench for clock_stepper: directed scenarios plus random stimulus, every cycle
// compared against a behavioural model of boot, modes, debounce and bursts.
module tb_clock_stepper;

   localparam int BOOT = 8;
   localparam int DEBN = 16;
   localparam int MD_HALT = 0, MD_RUN = 1, MD_SLOW = 2;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic [1:0]  mode = 2'b01;
   logic [4:0]  slow_sel = '0;
   logic        step_btn = 1'b0;
   logic        burst_go = 1'b0;
   logic [7:0]  burst_len = '0;
   logic        ce, resetn, busy;
   logic [31:0] cycle_count;

   int total = 0;
   int bad = 0;

   clock_stepper #(.BOOT_CYCLES(BOOT), .DIV_BITS(24), .DEB_BITS(4), .BURST_BITS(8)) dut (
      .CLK(CLK), .RESET(RESET), .mode(mode), .slow_sel(slow_sel), .step_btn(step_btn),
      .burst_go(burst_go), .burst_len(burst_len), .ce(ce), .resetn(resetn), .busy(busy),
      .cycle_count(cycle_count)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // behavioural model
   bit          m_valid = 1'b0;
   bit          m_in_boot, m_level, m_rise, m_ce, m_rn, m_busy;
   int          m_boot_age, m_burst_left, m_cur, m_slow_age;
   logic [31:0] m_count;
   bit          m_raw[$];

   always @(posedge CLK) begin : model
      bit nce, mism, v;
      int idx, p;
      if (RESET) begin
         m_valid = 1'b1; m_in_boot = 1'b1; m_boot_age = 0; m_burst_left = 0;
         m_cur = MD_HALT; m_slow_age = 0; m_level = 1'b0; m_rise = 1'b0;
         m_raw.delete(); m_ce = 1'b0; m_rn = 1'b0; m_busy = 1'b1; m_count = '0;
      end else begin
         m_count = m_count + 32'(m_ce);
         nce = 1'b0;
         if (m_in_boot) begin
            if (m_boot_age == BOOT - 1) begin
               m_in_boot = 1'b0;
               m_slow_age = 0;
               m_cur = (mode == 2'b01) ? MD_RUN : (mode == 2'b10) ? MD_SLOW : MD_HALT;
            end else m_boot_age++;
         end else if (m_burst_left > 0) begin
            if (m_burst_left == 1) begin m_burst_left = 0; m_cur = MD_HALT; end
            else begin m_burst_left--; nce = 1'b1; end
         end else if (mode == 2'b01) begin
            m_cur = MD_RUN; nce = 1'b1;
         end else if (mode == 2'b10) begin
            if (m_cur != MD_SLOW) begin m_cur = MD_SLOW; m_slow_age = 0; end
            else begin
               p = 1 << slow_sel;
               nce = ((m_slow_age % p) == p - 1);
               m_slow_age++;
            end
         end else begin
            if (m_cur == MD_HALT && burst_go && burst_len != 0) begin
               m_burst_left = int'(burst_len); nce = 1'b1;
            end else if (m_cur == MD_HALT && m_rise) nce = 1'b1;
            m_cur = MD_HALT;
         end
         // level flips once the synchronised input (raw delayed 2) differed for DEBN samples
         m_raw.push_back(step_btn);
         if (m_raw.size() > 40) void'(m_raw.pop_front());
         mism = 1'b1;
         for (int j = 0; j < DEBN; j++) begin
            idx = m_raw.size() - 3 - j;
            v = (idx >= 0) ? m_raw[idx] : 1'b0;
            if (v == m_level) mism = 1'b0;
         end
         m_rise = 1'b0;
         if (mism) begin m_level = !m_level; m_rise = m_level; end
         m_ce = nce; m_rn = !m_in_boot; m_busy = m_in_boot || (m_burst_left > 0);
      end
   end

   always @(posedge CLK) begin
      #1;
      if (m_valid) begin
         check("model_ce", 32'(ce), 32'(m_ce));
         check("model_resetn", 32'(resetn), 32'(m_rn));
         check("model_busy", 32'(busy), 32'(m_busy));
         check("model_count", cycle_count, m_count);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   initial begin
      int n, first, last, hold;
      // boot
      repeat (3) @(negedge CLK);
      RESET = 1'b0;
      check("reset_count", cycle_count, 32'd0);
      check("reset_busy", 32'(busy), 32'd1);
      for (int i = 0; i < 8; i++) begin
         check("boot_resetn", 32'(resetn), 32'd0);
         check("boot_ce", 32'(ce), 32'd0);
         @(negedge CLK);
      end
      check("boot_release", 32'(resetn), 32'd1);
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         check("run_ce", 32'(ce), 32'd1);
      end
      @(negedge CLK);
      check("run_count10", cycle_count, 32'd10);

      // wrap
      force dut.cycle_count = 32'hFFFF_FFFF;
      m_count = 32'hFFFF_FFFF;
      #4;
      release dut.cycle_count;
      @(negedge CLK);
      check("wrap0", cycle_count, 32'd0);
      @(negedge CLK);
      check("wrap1", cycle_count, 32'd1);

      // slow
      mode = 2'b00;
      repeat (3) @(negedge CLK);
      mode = 2'b10; slow_sel = 5'd3;
      @(negedge CLK);
      for (int k = 1; k <= 24; k++) begin
         @(negedge CLK);
         check("slow8", 32'(ce), 32'((k % 8) == 0));
      end
      slow_sel = 5'd0;
      for (int k = 0; k < 5; k++) begin
         @(negedge CLK);
         check("slow1", 32'(ce), 32'd1);
      end

      // step debounce
      mode = 2'b00;
      repeat (3) @(negedge CLK);
      n = 0;
      step_btn = 1'b1;
      for (int k = 0; k < 10; k++) begin @(negedge CLK); n += int'(ce); end
      step_btn = 1'b0;
      for (int k = 0; k < 30; k++) begin @(negedge CLK); n += int'(ce); end
      check("short_press", 32'(n), 32'd0);
      n = 0; first = 0;
      step_btn = 1'b1;
      for (int k = 1; k <= 70; k++) begin
         @(negedge CLK);
         if (ce) begin n++; if (first == 0) first = k; end
         if (k >= 40 && k <= 60) step_btn = (((k - 40) / 2) % 2) == 1;
         else if (k > 60) step_btn = 1'b0;
      end
      check("long_press_n", 32'(n), 32'd1);
      check("long_press_lat", 32'(first), 32'd19);
      n = 0;
      for (int k = 0; k < 40; k++) begin @(negedge CLK); n += int'(ce); end
      check("release", 32'(n), 32'd0);

      // burst with mid-burst requests
      burst_len = 8'd5; burst_go = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         @(negedge CLK);
         burst_go = (k == 2);
         check("burst_ce", 32'(ce), 32'(k <= 5 || k == 7));
         check("burst_busy", 32'(busy), 32'(k <= 5));
         if (k == 2) mode = 2'b01;
      end
      mode = 2'b00;
      repeat (3) @(negedge CLK);

      // zero-length burst
      burst_len = 8'd0; burst_go = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge CLK);
         burst_go = 1'b0;
         check("burst0_ce", 32'(ce), 32'd0);
         check("burst0_busy", 32'(busy), 32'd0);
      end

      // max-length burst
      burst_len = 8'd255; burst_go = 1'b1;
      n = 0; first = 0; last = 0;
      for (int k = 1; k <= 260; k++) begin
         @(negedge CLK);
         burst_go = 1'b0;
         if (ce) begin n++; if (first == 0) first = k; last = k; end
      end
      check("burst255_n", 32'(n), 32'd255);
      check("burst255_first", 32'(first), 32'd1);
      check("burst255_last", 32'(last), 32'd255);

      // reset in burst cycle 3
      burst_len = 8'd20; burst_go = 1'b1;
      @(negedge CLK); burst_go = 1'b0;
      repeat (2) @(negedge CLK);
      RESET = 1'b1;
      @(negedge CLK);
      check("rst_ce", 32'(ce), 32'd0);
      check("rst_resetn", 32'(resetn), 32'd0);
      check("rst_count", cycle_count, 32'd0);
      check("rst_busy", 32'(busy), 32'd1);
      RESET = 1'b0;
      repeat (7) @(negedge CLK);
      check("reboot_hold", 32'(resetn), 32'd0);
      @(negedge CLK);
      check("reboot_release", 32'(resetn), 32'd1);

      // random
      hold = 0;
      for (int i = 0; i < 800; i++) begin
         @(negedge CLK);
         if (hold == 0) begin step_btn = 1'($urandom_range(0, 1)); hold = $urandom_range(1, 40); end
         hold--;
         if ($urandom_range(0, 24) == 0) mode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 9) == 0) slow_sel = 5'($urandom_range(0, 4));
         burst_go = ($urandom_range(0, 19) == 0);
         burst_len = 8'($urandom_range(0, 12));
         RESET = ($urandom_range(0, 299) == 0);
      end
      RESET = 1'b0; burst_go = 1'b0;
      repeat (2) @(negedge CLK);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/clock_stepper.md
Name: clock_stepper

Overview:
- Run/halt/step controller that sequences the design's clock enable.
- Holds the design in reset for a boot window after RESET, because iCE40 BRAM returns garbage in its first microseconds.
- After boot, a single-cycle `ce` strobe drives every enabled register in the design. Modes: free-run, power-of-two slow, halt with debounced single-step, or an N-cycle burst.
- Sits between the board pins and the core.

Parameters:
- BOOT_CYCLES, 4096: cycles `resetn` is held low after RESET deasserts (range 1..65535).
- DIV_BITS, 24: width of the slow-mode divider counter.
- DEB_BITS, 16: debounce counter width; a level must be stable for 2^DEB_BITS cycles.
- BURST_BITS, 8: width of `burst_len`.

Ports:
- CLK, input, 1: board clock, sole clock.
- RESET, input, 1: synchronous, active-high reset.
- mode, input, 2: 00 halt, 01 run, 10 slow, 11 treated as halt.
- slow_sel, input, 5: slow-mode exponent s; `ce` fires every 2^s cycles.
- step_btn, input, 1: raw asynchronous step button, active-high.
- burst_go, input, 1: one-cycle request to start a burst.
- burst_len, input, BURST_BITS: burst length in `ce` cycles.
- ce, output, 1: registered clock enable for the design.
- resetn, output, 1: registered active-low design reset.
- busy, output, 1: high in BOOT and BURST.
- cycle_count, output, 32: count of asserted `ce` cycles.

Behaviour:
- All outputs are registered and sampled on posedge CLK.
- A decision made in cycle t is visible on the outputs in cycle t+1.

Reset:
- RESET=1 forces state=BOOT, ce=0, resetn=0, busy=1, cycle_count=0.
- All internal counters and the debounce state are cleared.
- RESET mid-operation aborts any mode or burst immediately.

States:
- BOOT: boot counter increments from 0.
  - ce=0 throughout.
  - When the counter reaches BOOT_CYCLES-1, the next cycle sets resetn=1, busy=0, and the state is selected from `mode`.
  - `mode`, `burst_go` and steps are ignored during BOOT.
- HALT (mode 00/11): ce=0.
  - A debounced rising edge of `step_btn` gives exactly one ce=1 cycle.
  - burst_go=1 with burst_len!=0 loads the burst counter with `burst_len` and enters BURST.
  - burst_go with burst_len=0 is ignored.
  - If a step pulse and burst_go arrive in the same cycle, the burst wins and the step is dropped.
- RUN (mode 01): ce=1 every cycle.
- SLOW (mode 10): the divider counter is cleared on entry and increments every cycle.
  - mask = 2^min(s, DIV_BITS) - 1.
  - ce=1 in the cycle the state decision sees (div_cnt & mask) == mask, so the first ce is 2^s cycles after entry.
  - s=0 gives ce every cycle.
  - `slow_sel` may change on the fly; the mask applies from the next cycle and the counter is not cleared.
- BURST: ce=1 for exactly `burst_len` consecutive cycles, then returns to HALT (ce=0 the next cycle).
  - `mode`, `burst_go` and steps are ignored until the burst completes.
  - busy=1 from the cycle after burst_go through the last ce cycle.
- Mode changes outside BOOT/BURST take effect the cycle after they are sampled.
  - Leaving SLOW discards the divider phase.

Debounce:
- `step_btn` passes through a 2-flop synchronizer, giving `sync`.
- The debounce counter clears on any cycle where sync equals the debounced level; otherwise it increments.
- When the counter reaches all-ones, the debounced level toggles and the counter clears.
- In HALT, a debounced 0→1 transition produces a ce pulse on the following cycle.
- Edges occurring outside HALT are discarded, not queued.
- Button release produces nothing.

cycle_count:
- Increments by 1 in each cycle where ce=1, wrapping at 2^32.
- Cleared only by RESET.

Test Plan:
- Use BOOT_CYCLES=8 and DEB_BITS=4 in the bench.
- Boot: RESET high 3 cycles, then low, mode=01 → resetn=0 and ce=0 for 8 cycles; resetn=1 on the 9th; ce=1 every cycle after that; cycle_count=10 after 10 run cycles.
- Slow: mode=10, slow_sel=3 from HALT → ce high once every 8 cycles, first on cycle 8 after entry; switch to slow_sel=0 → ce every cycle.
- Step debounce: mode=00; `step_btn` high for 10 cycles → no ce. Then high for 40 cycles → exactly one ce pulse, 2 + 16 + 1 cycles after the rise. Bouncing the release 5 times → no ce.
- Burst: mode=00, burst_go with burst_len=5 → busy=1 and exactly 5 consecutive ce cycles, then HALT. A burst_go and mode=01 issued mid-burst are ignored until completion, then RUN begins.
- Boundaries: burst_go with burst_len=0 → no ce, busy stays 0. burst_len=255 → 255 ce cycles. RESET asserted in burst cycle 3 → ce=0, resetn=0, cycle_count=0 the next cycle, boot restarts.
- Wrap: force cycle_count to 32'hFFFF_FFFF in RUN → next value 0.
